// File: rtl/minmax_burst_loader.sv
// ============================================================================
// Module   : minmax_burst_loader
// Purpose  : Buffers (addr,data) pairs and replays them as one gap-free burst
//            to the min/max search stage, then waits for its result valid.
//            Optional macro MINMAX_LOADER_DEDUP_EN merges repeated addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minmax_burst_loader #(
    parameter int AW    = 4,
    parameter int DW    = 5,
    parameter int DEPTH = 16,
    parameter int TMO   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [AW-1:0]               in_addr,
    input  logic [DW-1:0]               in_data,
    input  logic                        in_last,
    output logic                        s_vi,
    output logic                        takein,
    output logic [AW-1:0]               ai,
    output logic [DW-1:0]               di,
    input  logic                        vo_in,
    output logic                        busy,
    output logic [$clog2(DEPTH):0]      burst_len,
    output logic                        trunc,
    output logic                        done,
    output logic                        err_tmo
);

    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam int c_SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        BURST    = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [c_CW-1:0]    r_count;
    logic [c_CW-1:0]    r_rd;
    logic [c_CW-1:0]    r_len;
    logic [c_TW-1:0]    r_tmo;
    logic [AW+DW-1:0]   r_buf [DEPTH];
    logic               r_svi;
    logic               r_takein;
    logic [AW-1:0]      r_ai;
    logic [DW-1:0]      r_di;
    logic               r_busy;
    logic               r_trunc;
    logic               r_done;
    logic               r_err;

    logic [c_CW-1:0]    w_count_nxt;
    logic [c_SW-1:0]    w_wr_idx;
    logic               w_accept;
    logic               w_close;
    logic               w_tmo_hit;
    logic               w_release;

    assign in_ready  = (r_state == COLLECT) && (r_count < c_CW'(DEPTH));
    assign w_accept  = in_valid && in_ready;
    assign w_close   = w_accept && (in_last || (w_count_nxt == c_CW'(DEPTH)));
    assign w_tmo_hit = (TMO != 0) && (r_tmo == c_TW'(TMO - 1));
    assign w_release = (r_state == WAIT_RES) && (w_state_nxt == COLLECT);

`ifdef MINMAX_LOADER_DEDUP_EN
    logic [2**AW-1:0]   r_occ;
    logic [c_SW-1:0]    r_slot [2**AW];
    logic               w_dup;

    assign w_dup       = r_occ[in_addr];
    assign w_wr_idx    = w_dup ? r_slot[in_addr] : r_count[c_SW-1:0];
    assign w_count_nxt = w_dup ? r_count : r_count + c_CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (w_release) begin
            r_occ <= '0;
        end else if (w_accept && !w_dup) begin
            r_occ[in_addr] <= 1'b1;
        end
    end

    // Slot map needs no reset: an entry is only read while its occupied bit is set.
    always_ff @(posedge clk) begin
        if (w_accept && !w_dup) begin
            r_slot[in_addr] <= r_count[c_SW-1:0];
        end
    end
`else
    assign w_wr_idx    = r_count[c_SW-1:0];
    assign w_count_nxt = r_count + c_CW'(1);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT:  if (w_close) w_state_nxt = BURST;
            BURST:    if (r_rd == r_len) w_state_nxt = WAIT_RES;
            WAIT_RES: if (vo_in || w_tmo_hit) w_state_nxt = COLLECT;
            default:  w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[w_wr_idx] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_rd     <= '0;
            r_len    <= '0;
            r_tmo    <= '0;
            r_svi    <= 1'b0;
            r_takein <= 1'b0;
            r_ai     <= '0;
            r_di     <= '0;
            r_busy   <= 1'b0;
            r_trunc  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= (w_state_nxt != COLLECT);
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_count <= w_count_nxt;
                        if (w_close) begin
                            r_len   <= w_count_nxt;
                            r_rd    <= '0;
                            r_trunc <= !in_last && (w_count_nxt == c_CW'(DEPTH));
                        end
                    end
                end
                BURST: begin
                    if (r_rd == r_len) begin
                        r_svi <= 1'b0;
                        r_tmo <= '0;
                    end else begin
                        r_svi        <= 1'b1;
                        r_takein     <= 1'b1;
                        {r_ai, r_di} <= r_buf[r_rd[c_SW-1:0]];
                        r_rd         <= r_rd + c_CW'(1);
                    end
                end
                WAIT_RES: begin
                    if (vo_in) begin
                        r_done   <= 1'b1;
                        r_count  <= '0;
                        r_takein <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_err    <= 1'b1;
                        r_count  <= '0;
                        r_takein <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + c_TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_vi      = r_svi;
    assign takein    = r_takein;
    assign ai        = r_ai;
    assign di        = r_di;
    assign busy      = r_busy;
    assign burst_len = r_len;
    assign trunc     = r_trunc;
    assign done      = r_done;
    assign err_tmo   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_minmax_burst_loader.sv
// ============================================================================
// Module   : tb_minmax_burst_loader
// Purpose  : Directed self-checking bench for minmax_burst_loader (main
//            instance TMO=255, second instance TMO=8 for the abort path).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minmax_burst_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_addr = '0;
    logic [4:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       vo_in = 1'b0;

    logic       in_ready, s_vi, takein, busy, trunc, done, err_tmo;
    logic [3:0] ai;
    logic [4:0] di;
    logic [4:0] burst_len;

    logic       in_ready_t, s_vi_t, takein_t, busy_t, trunc_t, done_t, err_tmo_t;
    logic [3:0] ai_t;
    logic [4:0] di_t;
    logic [4:0] burst_len_t;

    int n_chk  = 0;
    int n_fail = 0;

    minmax_burst_loader #(.AW(4), .DW(5), .DEPTH(16), .TMO(255)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
        .s_vi(s_vi), .takein(takein), .ai(ai), .di(di), .vo_in(vo_in),
        .busy(busy), .burst_len(burst_len), .trunc(trunc), .done(done),
        .err_tmo(err_tmo)
    );

    minmax_burst_loader #(.AW(4), .DW(5), .DEPTH(16), .TMO(8)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
        .s_vi(s_vi_t), .takein(takein_t), .ai(ai_t), .di(di_t), .vo_in(vo_in),
        .busy(busy_t), .burst_len(burst_len_t), .trunc(trunc_t), .done(done_t),
        .err_tmo(err_tmo_t)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {in_ready,s_vi,takein,busy,trunc,done,err_tmo,ai,di,burst_len}
    task automatic chk_reset(input string tag);
        chk(tag, {in_ready, s_vi, takein, busy, trunc, done, err_tmo, ai, di, burst_len},
            {1'b1, 6'b0, 4'd0, 5'd0, 5'd0});
    endtask

    task automatic send(input logic [3:0] a, input logic [4:0] d, input logic l);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_vo();
        vo_in = 1'b1;
        tick();
        vo_in = 1'b0;
    endtask

    logic [8:0] exp_q[$];

    initial begin
        // ---------------- reset state
        tick();
        tick();
        chk_reset("reset_state");
        rst = 1'b0;

        // ---------------- 3-pair batch
        send(4'd0, 5'd15, 1'b0);
        send(4'd15, 5'd28, 1'b0);
        send(4'd13, 5'd6, 1'b1);
        chk("close_svi_ready_busy", {s_vi, in_ready, busy}, 3'b001);
        chk("burst_len_3", burst_len, 5'd3);
        tick();
        chk("b3_beat0", {s_vi, takein, ai, di}, {2'b11, 4'd0, 5'd15});
        tick();
        chk("b3_beat1", {s_vi, ai, di}, {1'b1, 4'd15, 5'd28});
        tick();
        chk("b3_beat2", {s_vi, ai, di, busy}, {1'b1, 4'd13, 5'd6, 1'b1});
        tick();
        chk("b3_end_hold", {s_vi, takein, ai, di}, {2'b01, 4'd13, 5'd6});
        for (int i = 0; i < 20; i++) tick();
        chk("wait20_no_done", {done, busy, takein, in_ready}, 4'b0110);
        pulse_vo();
        chk("done_pulse", {done, in_ready, takein, busy}, 4'b1100);
        tick();
        chk("done_once", done, 1'b0);

        // ---------------- 17 pairs, truncation at DEPTH
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_addr  = 4'(i);
            in_data  = 5'(i + 1);
            tick();
        end
        chk("trunc_pulse", {trunc, in_ready, busy}, 3'b101);
        chk("burst_len_16", burst_len, 5'd16);
        in_addr = 4'd3;
        in_data = 5'd31;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("b16_beat", {s_vi, ai, di, trunc, in_ready}, {1'b1, 4'(i), 5'(i + 1), 2'b00});
        end
        tick();
        chk("b16_end", {s_vi, in_ready, busy}, 3'b001);
        tick();
        tick();
        chk("held_not_taken", in_ready, 1'b0);
        vo_in = 1'b1;
        tick();
        vo_in = 1'b0;
        chk("b16_done", {done, in_ready}, 2'b11);
        tick();
        send(4'd4, 5'd7, 1'b1);
        chk("burst_len_after_held", {burst_len, busy}, {5'd2, 1'b1});
        tick();
        chk("held_beat0", {s_vi, ai, di}, {1'b1, 4'd3, 5'd31});
        tick();
        chk("held_beat1", {s_vi, ai, di}, {1'b1, 4'd4, 5'd7});
        tick();
        chk("held_end", s_vi, 1'b0);
        pulse_vo();

        // ---------------- timeout abort (TMO=8 instance)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(4'd1, 5'd1, 1'b1);
        tick();
        chk("tmo_beat0", {s_vi_t, ai_t, di_t}, {1'b1, 4'd1, 5'd1});
        tick();
        chk("tmo_wait_entry", {s_vi_t, busy_t, takein_t}, 3'b011);
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_not_yet", {err_tmo_t, busy_t}, 2'b01);
        tick();
        chk("tmo_fire", {err_tmo_t, busy_t, done_t, in_ready_t, takein_t}, 5'b10010);
        tick();
        chk("tmo_once", err_tmo_t, 1'b0);
        chk("tmo255_still_wait", {busy, err_tmo}, 2'b10);

        // ---------------- reset during the 2nd beat of a burst
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(4'd7, 5'd2, 1'b0);
        send(4'd8, 5'd3, 1'b0);
        send(4'd9, 5'd4, 1'b1);
        tick();
        tick();
        chk("pre_rst_beat1", {s_vi, ai, di}, {1'b1, 4'd8, 5'd3});
        #2;
        rst = 1'b1;
        #1;
        chk_reset("mid_burst_reset");
        tick();
        #2;
        rst = 1'b0;
        tick();
        send(4'd6, 5'd5, 1'b1);
        chk("single_len", burst_len, 5'd1);
        tick();
        chk("single_beat", {s_vi, ai, di}, {1'b1, 4'd6, 5'd5});
        tick();
        chk("single_one_cycle", {s_vi, busy}, 2'b01);
        pulse_vo();

        // ---------------- duplicate addresses
        send(4'd5, 5'd3, 1'b0);
        send(4'd5, 5'd20, 1'b0);
        send(4'd2, 5'd9, 1'b1);
`ifdef MINMAX_LOADER_DEDUP_EN
        exp_q = '{ {4'd5, 5'd20}, {4'd2, 5'd9} };
`else
        exp_q = '{ {4'd5, 5'd3}, {4'd5, 5'd20}, {4'd2, 5'd9} };
`endif
        chk("dup_len", burst_len, 5'(exp_q.size()));
        foreach (exp_q[i]) begin
            tick();
            chk("dup_beat", {s_vi, ai, di}, {1'b1, exp_q[i]});
        end
        tick();
        chk("dup_end", s_vi, 1'b0);
        pulse_vo();
        chk("dup_done", {done, in_ready}, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
